event_count_gate: RTL and testbench
===================================

# event_count_gate

Input-conditioning and gating sequencer that sits directly upstream of the team's 4-bit synchronous counter stage. It synchronises and debounces a raw asynchronous event line, presets the counter, and converts each qualified rising edge into a one-cycle count enable during a programmable measurement window. It also flags counter wrap-around via the counter's ripple-carry. It drives the counter's D, LOAD_n, ENP and ENT directly, and observes its RCO.

## Interface
Parameters:
- SYNC_STAGES, 2, synchroniser depth on EVT_IN (legal ≥2)
- DEB_W, 8, width of debounce length
- GATE_W, 16, width of gate length

Ports:
- CLK  in  1  clock; all state updates on rising edge
- CLR_n  in  1  reset, asynchronous, active-low
- EVT_IN  in  1  raw asynchronous event input
- DEB_LEN  in  DEB_W  extra stable cycles required before filtered level changes; sampled continuously
- GATE_LEN  in  GATE_W  window length in cycles; captured on accepted START
- PRESET  in  4  counter preset value; captured on accepted START
- START  in  1  begin measurement; honoured only in IDLE
- RCO_IN  in  1  ripple-carry from counter
- D  out  4  counter parallel-load data
- LOAD_n  out  1  counter load, active-low
- ENP  out  1  counter count-enable (per-event pulse)
- ENT  out  1  counter trickle enable (window)
- BUSY  out  1  high in LOAD and GATE
- DONE  out  1  one-cycle pulse at end of window
- OVF  out  1  sticky wrap flag

## Operation
- Sync chain: SYNC_STAGES flops. Output is synced level S.
- Debounce: filtered level F and counter DC.
  - If S == F, DC clears to 0.
  - Else DC increments. When DC == DEB_LEN, F takes S and DC clears to 0.
  - DEB_LEN = 0 means F follows S one cycle later.
- Rise detect: a rise occurs in any cycle where F goes 0→1. Falling edges never count.
- FSM states: IDLE, LOAD, GATE, DONE.
  - IDLE → LOAD on START=1. Captures PRESET and GATE_LEN.
  - LOAD → GATE if captured GATE_LEN ≠ 0, else → DONE. LOAD lasts exactly 1 cycle.
  - GATE → DONE when the gate counter reaches GATE_LEN−1. GATE lasts exactly GATE_LEN cycles.
  - DONE → IDLE unconditionally. DONE lasts 1 cycle.
- START in LOAD, GATE or DONE is ignored; it is not queued.
- All outputs are registered.
  - LOAD_n=0 only in LOAD.
  - D holds captured PRESET from LOAD onward until the next accepted START.
  - ENT=1 exactly in GATE cycles.
  - ENP=1 for one cycle per rise, only while ENT=1.
- Rises outside GATE are discarded. The filter keeps tracking regardless of state.
- OVF:
  - Cleared in the LOAD cycle.
  - Set at a clock edge where ENP=1, ENT=1 and RCO_IN=1.
  - Holds through DONE and IDLE until the next accepted START.
- Gate counter is GATE_W bits and never wraps within a window.

## Timing
- Reset values (CLR_n low, immediate, any state):
  - state IDLE, D=0, LOAD_n=1, ENP=0, ENT=0, BUSY=0, DONE=0, OVF=0
  - F=0, DC=0, sync flops 0, gate counter 0
- START sampled high at edge k:
  - LOAD_n=0 and BUSY=1 in cycle k+1.
  - ENT=1 in cycles k+2 … k+1+GATE_LEN.
  - DONE=1 in cycle k+2+GATE_LEN, with BUSY=0.
- If GATE_LEN=0: DONE=1 in cycle k+2.
- Event latency: EVT_IN first sampled high at edge e and held. ENP goes high in the cycle after edge e+SYNC_STAGES+DEB_LEN, provided that cycle is a GATE cycle.
- Minimum event spacing for distinct counts: high DEB_LEN+1 cycles, then low DEB_LEN+1 cycles.
- Rise landing exactly on the first or last GATE cycle is counted.
- CLR_n deasserted mid-window: the block restarts in IDLE and needs a fresh START.

## Test plan
- Reset mid-GATE (CLR_n low 1 cycle) → same-cycle LOAD_n=1, ENP=0, ENT=0, BUSY=0, OVF=0; START ignored until CLR_n high; next START works normally.
- PRESET=4'hA, GATE_LEN=20, DEB_LEN=0, 3 clean pulses (4 high / 4 low) inside window → one LOAD_n=0 cycle with D=4'hA, 20 ENT cycles, exactly 3 ENP pulses, DONE at k+22, OVF=0.
- DEB_LEN=3, glitches of 1–3 cycles high, then one 6-cycle pulse → exactly 1 ENP, asserted SYNC_STAGES+4 cycles after the pulse's first sampling edge.
- PRESET=4'hE, RCO_IN driven high when the counter model reaches 4'hF, 2 events → OVF=1 after the second ENP; OVF stays 1 through IDLE; cleared in LOAD of the next START.
- GATE_LEN=0, START pulse → LOAD at k+1, DONE at k+2, ENT never 1; START held high through the whole sequence → second run starts only after returning to IDLE.
- Events during IDLE/LOAD/DONE plus one event aligned to the last GATE cycle → only the aligned event produces an ENP.

Source files
------------

// File: rtl/event_count_gate.sv
// Conditions a raw event line (sync + debounce) and gates each qualified rise into a
// one-cycle count enable for a downstream 4-bit counter during a programmable window.
module event_count_gate #(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_W       = 8,
  parameter int GATE_W      = 16
) (
  input  logic              CLK,
  input  logic              CLR_n,
  input  logic              EVT_IN,
  input  logic [DEB_W-1:0]  DEB_LEN,
  input  logic [GATE_W-1:0] GATE_LEN,
  input  logic [3:0]        PRESET,
  input  logic              START,
  input  logic              RCO_IN,
  output logic [3:0]        D,
  output logic              LOAD_n,
  output logic              ENP,
  output logic              ENT,
  output logic              BUSY,
  output logic              DONE,
  output logic              OVF
);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_GATE, ST_DONE} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   filt_q, filt_d;
  logic [DEB_W-1:0]       dc_q, dc_d;
  logic [GATE_W-1:0]      gcnt_q, gcnt_d;
  logic [GATE_W-1:0]      glen_q, glen_d;
  logic [3:0]             dout_q, dout_d;
  logic                   load_n_q, load_n_d;
  logic                   enp_q, enp_d;
  logic                   ent_q, ent_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   ovf_q, ovf_d;
  logic                   sync_s;
  logic                   rise;

  assign sync_s = sync_q[SYNC_STAGES-1];

  // Filtered level only moves after S has disagreed with it for DEB_LEN+1 cycles.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], EVT_IN};
    filt_d = filt_q;
    dc_d   = '0;
    if (sync_s != filt_q) begin
      if (dc_q == DEB_LEN) begin
        filt_d = sync_s;
      end else begin
        dc_d = dc_q + 1'b1;
      end
    end
    rise = filt_d & ~filt_q;
  end

  always_comb begin
    state_d = state_q;
    gcnt_d  = gcnt_q;
    glen_d  = glen_q;
    dout_d  = dout_q;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d = ST_LOAD;
          glen_d  = GATE_LEN;
          dout_d  = PRESET;
        end
      end
      ST_LOAD: begin
        gcnt_d  = '0;
        state_d = (glen_q != '0) ? ST_GATE : ST_DONE;
      end
      ST_GATE: begin
        if (gcnt_q == glen_q - 1'b1) begin
          state_d = ST_DONE;
        end else begin
          gcnt_d = gcnt_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the registered state.
  always_comb begin
    load_n_d = (state_d != ST_LOAD);
    ent_d    = (state_d == ST_GATE);
    busy_d   = (state_d == ST_LOAD) || (state_d == ST_GATE);
    done_d   = (state_d == ST_DONE);
    enp_d    = rise && ent_d;
    ovf_d    = ovf_q | (enp_q & ent_q & RCO_IN);
    if (state_d == ST_LOAD) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge CLR_n) begin
    if (!CLR_n) begin
      state_q  <= ST_IDLE;
      sync_q   <= '0;
      filt_q   <= 1'b0;
      dc_q     <= '0;
      gcnt_q   <= '0;
      glen_q   <= '0;
      dout_q   <= 4'h0;
      load_n_q <= 1'b1;
      enp_q    <= 1'b0;
      ent_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync_q   <= sync_d;
      filt_q   <= filt_d;
      dc_q     <= dc_d;
      gcnt_q   <= gcnt_d;
      glen_q   <= glen_d;
      dout_q   <= dout_d;
      load_n_q <= load_n_d;
      enp_q    <= enp_d;
      ent_q    <= ent_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
    end
  end

  assign D      = dout_q;
  assign LOAD_n = load_n_q;
  assign ENP    = enp_q;
  assign ENT    = ent_q;
  assign BUSY   = busy_q;
  assign DONE   = done_q;
  assign OVF    = ovf_q;

endmodule

// File: tb/tb_event_count_gate.sv
// Bench for event_count_gate: window-timing/event-window model checked every cycle,
// plus directed scenarios with hand-computed counts and edge offsets.
module tb_event_count_gate;
  localparam int SS = 2;
  localparam int M_IDLE = 0, M_LOAD = 1, M_GATE = 2, M_DONE = 3;

  logic        CLK = 1'b0;
  logic        CLR_n, EVT_IN, START, RCO_IN;
  logic [7:0]  DEB_LEN;
  logic [15:0] GATE_LEN;
  logic [3:0]  PRESET, D;
  logic        LOAD_n, ENP, ENT, BUSY, DONE, OVF;

  event_count_gate #(.SYNC_STAGES(SS), .DEB_W(8), .GATE_W(16)) dut (
    .CLK(CLK), .CLR_n(CLR_n), .EVT_IN(EVT_IN), .DEB_LEN(DEB_LEN), .GATE_LEN(GATE_LEN),
    .PRESET(PRESET), .START(START), .RCO_IN(RCO_IN), .D(D), .LOAD_n(LOAD_n),
    .ENP(ENP), .ENT(ENT), .BUSY(BUSY), .DONE(DONE), .OVF(OVF)
  );

  always #5 CLK = ~CLK;

  // Downstream 4-bit counter stand-in: provides RCO_IN.
  logic [3:0] cnt = 4'h0;
  always @(posedge CLK) begin
    if (!LOAD_n) cnt <= D;
    else if (ENP && ENT) cnt <= cnt + 4'h1;
  end
  assign RCO_IN = ENT && (cnt == 4'hF);

  // ---------------- behavioural model ----------------
  int   cyc = 0, base = 0;
  logic ev [0:4095];
  logic mf = 1'b0;
  bit   mact = 1'b0;
  int   mk = 0, mglen = 0;
  logic [3:0] e_d = 4'h0;
  logic e_load_n = 1'b1, e_enp = 1'b0, e_ent = 1'b0, e_busy = 1'b0, e_done = 1'b0, e_ovf = 1'b0;

  // synced level visible after edge n
  function automatic logic sval(int n);
    int i;
    i = n - SS + 1;
    if (i < base || i < 0 || i > 4095) return 1'b0;
    return ev[i];
  endfunction

  // window phase relative to the last accepted START edge
  function automatic int mstate(int n);
    int ph;
    if (!mact) return M_IDLE;
    ph = n - mk;
    if (ph == 0) return M_LOAD;
    if (ph >= 1 && ph <= mglen) return M_GATE;
    if (ph == mglen + 1) return M_DONE;
    return M_IDLE;
  endfunction

  initial begin
    forever begin
      bit flip, rise, ovf_set;
      int st;
      @(posedge CLK);
      cyc++;
      if (!CLR_n) begin
        base = cyc + 1; mf = 1'b0; mact = 1'b0;
        e_d = 4'h0; e_load_n = 1'b1; e_enp = 1'b0; e_ent = 1'b0;
        e_busy = 1'b0; e_done = 1'b0; e_ovf = 1'b0;
      end else begin
        if (cyc <= 4095) ev[cyc] = EVT_IN;
        // level changes once S has differed from it for DEB_LEN+1 straight cycles
        flip = 1'b1;
        for (int j = 0; j <= int'(DEB_LEN); j++)
          if (sval(cyc - 1 - j) == mf) flip = 1'b0;
        rise = flip && !mf;
        if (flip) mf = !mf;
        ovf_set = e_enp && e_ent && RCO_IN;
        if (START && mstate(cyc - 1) == M_IDLE) begin
          mact = 1'b1; mk = cyc; mglen = int'(GATE_LEN); e_d = PRESET;
        end
        st = mstate(cyc);
        e_load_n = (st != M_LOAD);
        e_ent    = (st == M_GATE);
        e_busy   = (st == M_LOAD) || (st == M_GATE);
        e_done   = (st == M_DONE);
        e_enp    = rise && (st == M_GATE);
        if (ovf_set) e_ovf = 1'b1;
        if (st == M_LOAD) e_ovf = 1'b0;
      end
    end
  end

  // ---------------- checking ----------------
  int n_cmp = 0, n_fail = 0;
  int enp_tot = 0, ent_tot = 0, load_tot = 0;
  int last_enp = -1, last_done = -1, last_load = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [9:0] outv();
    return {D, LOAD_n, ENP, ENT, BUSY, DONE, OVF};
  endfunction

  // One clock: compare against the model after the edge, tally, return at negedge.
  task automatic step();
    @(posedge CLK);
    #2;
    chk("cycle_outputs", outv(), {e_d, e_load_n, e_enp, e_ent, e_busy, e_done, e_ovf});
    if (ENP) begin enp_tot++; last_enp = cyc; end
    if (ENT) ent_tot++;
    if (DONE) last_done = cyc;
    if (!LOAD_n) begin load_tot++; last_load = cyc; end
    @(negedge CLK);
  endtask

  task automatic do_start(input logic [3:0] p, input logic [15:0] g, output int k);
    PRESET = p; GATE_LEN = g; START = 1'b1;
    step();
    START = 1'b0;
    k = cyc;
  endtask

  task automatic pulse(input int h, input int l);
    EVT_IN = 1'b1;
    repeat (h) step();
    EVT_IN = 1'b0;
    repeat (l) step();
  endtask

  task automatic run_pattern(input int s0, input logic [15:0] g, input logic [31:0] bits, input int len);
    GATE_LEN = g;
    for (int t = 0; t < len; t++) begin
      START  = (t == s0);
      EVT_IN = bits[t];
      step();
    end
    START = 1'b0; EVT_IN = 1'b0;
  endtask

  initial begin
    int k, e, t0, s_enp, s_ent, s_load;
    CLR_n = 1'b0; EVT_IN = 1'b0; START = 1'b0;
    DEB_LEN = 8'd0; GATE_LEN = 16'd0; PRESET = 4'h0;
    step(); step();
    chk("reset_values", outv(), 10'h020);
    CLR_n = 1'b1;
    step(); step();

    // reset in the middle of a window
    do_start(4'h5, 16'd20, k);
    repeat (5) step();
    CLR_n = 1'b0; START = 1'b1;
    #1;
    chk("t1_async_reset", outv(), 10'h020);
    step();
    CLR_n = 1'b1; START = 1'b0;
    step();
    chk("t1_idle_after_reset", {LOAD_n, BUSY, ENT}, 3'b100);
    do_start(4'h3, 16'd2, k);
    chk("t1_restart_load", {D, LOAD_n}, {4'h3, 1'b0});
    repeat (4) step();
    chk("t1_restart_done", last_done - k, 3);

    // three clean pulses in a 20-cycle window
    s_enp = enp_tot; s_ent = ent_tot; s_load = load_tot;
    do_start(4'hA, 16'd20, k);
    chk("t2_load_d", {D, LOAD_n}, {4'hA, 1'b0});
    repeat (3) pulse(4, 4);
    chk("t2_ent_cycles", ent_tot - s_ent, 20);
    chk("t2_enp_pulses", enp_tot - s_enp, 3);
    chk("t2_done_edge", last_done - k, 21);
    chk("t2_load_cycles", load_tot - s_load, 1);
    chk("t2_ovf", OVF, 0);

    // debounce: glitches rejected, one long pulse counted
    DEB_LEN = 8'd3;
    repeat (4) step();
    s_enp = enp_tot;
    do_start(4'h0, 16'd60, k);
    pulse(1, 5); pulse(2, 5); pulse(3, 5);
    EVT_IN = 1'b1;
    step();
    e = cyc;
    repeat (5) step();
    EVT_IN = 1'b0;
    repeat (10) step();
    chk("t3_enp_pulses", enp_tot - s_enp, 1);
    chk("t3_enp_latency", last_enp - e, SS + 3);
    repeat (30) step();
    DEB_LEN = 8'd0;
    repeat (4) step();

    // wrap flag through ripple-carry
    s_enp = enp_tot;
    do_start(4'hE, 16'd30, k);
    repeat (2) pulse(4, 4);
    repeat (24) step();
    chk("t4_enp_pulses", enp_tot - s_enp, 2);
    chk("t4_ovf_after_window", OVF, 1);
    repeat (5) step();
    chk("t4_ovf_held_idle", {OVF, BUSY}, 2'b10);
    do_start(4'h0, 16'd4, k);
    chk("t4_ovf_cleared_in_load", {LOAD_n, OVF}, 2'b00);
    repeat (8) step();

    // zero-length window, then START held high
    s_ent = ent_tot;
    do_start(4'h0, 16'd0, k);
    chk("t5_load", LOAD_n, 0);
    step();
    chk("t5_done_k2", {DONE, BUSY, ENT}, 3'b100);
    step();
    s_load = load_tot;
    START = 1'b1;
    repeat (8) step();
    START = 1'b0;
    repeat (3) step();
    chk("t5_held_loads", load_tot - s_load, 3);
    chk("t5_held_last_load", last_load - k, 9);
    chk("t5_no_ent", ent_tot - s_ent, 0);

    // events in IDLE, LOAD, last GATE cycle; DONE; first GATE cycle
    repeat (3) step();
    s_enp = enp_tot; t0 = cyc + 1;
    run_pattern(10, 16'd10, 32'h000C_030F, 26);
    repeat (4) step();
    chk("t6_only_aligned", enp_tot - s_enp, 1);
    chk("t6_last_gate_edge", last_enp - t0, 20);
    s_enp = enp_tot;
    run_pattern(2, 16'd3, 32'h0000_0030, 12);
    repeat (4) step();
    chk("t6_done_event", enp_tot - s_enp, 0);
    s_enp = enp_tot; t0 = cyc + 1;
    run_pattern(2, 16'd3, 32'h0000_0006, 12);
    repeat (4) step();
    chk("t6_first_gate", enp_tot - s_enp, 1);
    chk("t6_first_gate_edge", last_enp - t0, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
